// File: rtl/tw_horizontal_gen_if.sv
// Bus between the twiddle generator and its requester / the stage-0 twiddle ROM.
// The master side issues requests and observes the streamed words.
interface tw_horizontal_gen_if #(
    parameter int DW = 64
);
    logic          start;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic          busy;
    logic          done;
    logic [DW-1:0] horizontal_data_out;
    logic [1:0]    rom_w;

    modport master (
        output start, w_hi, w_lo,
        input  busy, done, horizontal_data_out, rom_w
    );

    modport slave (
        input  start, w_hi, w_lo,
        output busy, done, horizontal_data_out, rom_w
    );
endinterface

// File: rtl/tw_horizontal_gen.sv
// Computes w^0..w^3 (mod Goldilocks p) for two roots and streams them to the twiddle ROM:
// four high-half words (rom_w=1) followed immediately by four low-half words (rom_w=2).
module tw_horizontal_gen #(
    parameter int          DW      = 64,
    parameter logic [63:0] PRIME   = 64'hFFFF_FFFF_0000_0001,
    parameter int          ENTRIES = 4
) (
    input  logic                CLK,
    input  logic                rst_n,
    tw_horizontal_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MUL, S_RED, S_STREAM_HI, S_STREAM_LO, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DW-1:0]   root_hi_q, root_hi_d;
    logic [DW-1:0]   root_lo_q, root_lo_d;
    logic [DW-1:0]   buf_hi_q [ENTRIES];
    logic [DW-1:0]   buf_hi_d [ENTRIES];
    logic [DW-1:0]   buf_lo_q [ENTRIES];
    logic [DW-1:0]   buf_lo_d [ENTRIES];
    logic [2*DW-1:0] prod_q, prod_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      rom_w_q, rom_w_d;
    logic [DW-1:0]   op_a, op_b;

    function automatic logic [63:0] canonical(input logic [63:0] x);
        return (x >= PRIME) ? x - PRIME : x;
    endfunction

    // t0 - t2 + t1*(2^32-1) biased by +p so it never goes negative; the sum stays below 3p,
    // so one conditional 2p subtraction and one conditional p subtraction reach [0, p).
    function automatic logic [63:0] reduce(input logic [127:0] t);
        logic [63:0] t0;
        logic [63:0] t1m;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [65:0] x;
        t0  = t[63:0];
        t1  = t[95:64];
        t2  = t[127:96];
        t1m = {t1, 32'h0} - {32'h0, t1};
        x   = {2'b00, t0} + {2'b00, t1m} + {2'b00, PRIME} - {34'h0, t2};
        if (x >= {1'b0, PRIME, 1'b0}) x = x - {1'b0, PRIME, 1'b0};
        if (x >= {2'b00, PRIME})      x = x - {2'b00, PRIME};
        return x[63:0];
    endfunction

    // Product schedule: hi1*hi1, hi2*hi1, lo1*lo1, lo2*lo1.
    assign op_a = idx_q[1] ? (idx_q[0] ? buf_lo_q[2] : buf_lo_q[1])
                           : (idx_q[0] ? buf_hi_q[2] : buf_hi_q[1]);
    assign op_b = idx_q[1] ? buf_lo_q[1] : buf_hi_q[1];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        root_hi_d = root_hi_q;
        root_lo_d = root_lo_q;
        buf_hi_d  = buf_hi_q;
        buf_lo_d  = buf_lo_q;
        prod_d    = prod_q;
        data_d    = '0;
        rom_w_d   = 2'd0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    root_hi_d = bus.w_hi;
                    root_lo_d = bus.w_lo;
                    idx_d     = 2'd0;
                end
            end
            S_LOAD: begin
                buf_hi_d[0] = 64'd1;
                buf_lo_d[0] = 64'd1;
                buf_hi_d[1] = canonical(root_hi_q);
                buf_lo_d[1] = canonical(root_lo_q);
                idx_d       = 2'd0;
                state_d     = S_MUL;
            end
            S_MUL: begin
                prod_d  = op_a * op_b;
                state_d = S_RED;
            end
            S_RED: begin
                case (idx_q)
                    2'd0:    buf_hi_d[2] = reduce(prod_q);
                    2'd1:    buf_hi_d[3] = reduce(prod_q);
                    2'd2:    buf_lo_d[2] = reduce(prod_q);
                    default: buf_lo_d[3] = reduce(prod_q);
                endcase
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? S_STREAM_HI : S_MUL;
            end
            S_STREAM_HI: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_STREAM_LO;
            end
            S_STREAM_LO: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in the same
        // cycle the FSM enters that state; the index wraps 3->0 between the two halves.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_STREAM_HI) begin
            rom_w_d = 2'd1;
            data_d  = buf_hi_q[idx_d];
        end else if (state_d == S_STREAM_LO) begin
            rom_w_d = 2'd2;
            data_d  = buf_lo_q[idx_d];
        end
    end

    // NOTE: the power buffers are reset along with the control state so that no stale
    // twiddles from an aborted run can ever be streamed; plain storage would not need it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            root_hi_q <= '0;
            root_lo_q <= '0;
            buf_hi_q  <= '{default: '0};
            buf_lo_q  <= '{default: '0};
            prod_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            rom_w_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            root_hi_q <= root_hi_d;
            root_lo_q <= root_lo_d;
            buf_hi_q  <= buf_hi_d;
            buf_lo_q  <= buf_lo_d;
            prod_q    <= prod_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
            rom_w_q   <= rom_w_d;
        end
    end

    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.horizontal_data_out = data_q;
    assign bus.rom_w               = rom_w_q;

endmodule

// File: tb/tb_tw_horizontal_gen.sv
// Directed bench for tw_horizontal_gen: cycle-exact check of every output across each burst,
// plus re-trigger, start-in-DONE, mid-stream reset and back-to-back requests.
module tb_tw_horizontal_gen;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic CLK = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    tw_horizontal_gen_if bus ();

    tw_horizontal_gen dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues start in the current cycle (cycle 0) and checks cycles 1..19; returns in cycle 19.
    // retrig > 0 pulses start with unrelated roots during that cycle.
    task automatic run_burst(input string name, input logic [63:0] whi, input logic [63:0] wlo,
                             input logic [63:0] eh [4], input logic [63:0] el [4], input int retrig);
        int rom_cnt  = 0;
        int done_cnt = 0;
        logic [1:0]  exp_w;
        logic [63:0] exp_d;
        bus.start = 1'b1;
        bus.w_hi  = whi;
        bus.w_lo  = wlo;
        tick();
        bus.start = 1'b0;
        bus.w_hi  = ~whi;
        bus.w_lo  = ~wlo;
        for (int c = 1; c <= 19; c++) begin
            exp_w = 2'd0;
            exp_d = 64'd0;
            if (c >= 10 && c <= 13) begin
                exp_w = 2'd1;
                exp_d = eh[c-10];
            end else if (c >= 14 && c <= 17) begin
                exp_w = 2'd2;
                exp_d = el[c-14];
            end
            check($sformatf("%s c%0d rom_w", name, c), {62'd0, bus.rom_w}, {62'd0, exp_w});
            check($sformatf("%s c%0d data", name, c), bus.horizontal_data_out, exp_d);
            check($sformatf("%s c%0d done", name, c), {63'd0, bus.done}, {63'd0, c == 18});
            check($sformatf("%s c%0d busy", name, c), {63'd0, bus.busy}, {63'd0, c <= 18});
            if (bus.rom_w != 2'd0) rom_cnt++;
            if (bus.done) done_cnt++;
            if (c < 19) begin
                if (c == retrig) begin
                    bus.start = 1'b1;
                    bus.w_hi  = 64'd5;
                    bus.w_lo  = 64'd7;
                end
                tick();
                bus.start = 1'b0;
            end
        end
        check($sformatf("%s rom_w count", name), 64'(rom_cnt), 64'd8);
        check($sformatf("%s done count", name), 64'(done_cnt), 64'd1);
    endtask

    logic [63:0] pow_hi [4];
    logic [63:0] pow_lo [4];
    logic [63:0] edge_hi [4];
    logic [63:0] edge_lo [4];
    logic [63:0] nc_hi [4];
    logic [63:0] nc_lo [4];

    initial begin
        pow_hi  = '{64'd1, 64'h0200_0000_0000_0000, 64'hFFFF_FFFE_FFFC_0001, 64'hFFFF_F7FF_0000_0801};
        pow_lo  = '{64'd1, 64'h585b_da2e_086e_bc26, 64'h0000_0007_fff7_fff8, 64'h7202_dad8_187e_103f};
        edge_hi = '{64'd1, P - 64'd1, 64'd1, P - 64'd1};
        edge_lo = '{64'd1, 64'd0, 64'd0, 64'd0};
        nc_hi   = '{64'd1, 64'd0, 64'd0, 64'd0};
        nc_lo   = '{64'd1, 64'd2, 64'd4, 64'd8};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.w_hi  = '0;
        bus.w_lo  = '0;
        tick();
        tick();
        check("reset rom_w", {62'd0, bus.rom_w}, 64'd0);
        check("reset data", bus.horizontal_data_out, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_burst("pow2", 64'h0200_0000_0000_0000, 64'h585b_da2e_086e_bc26, pow_hi, pow_lo, 0);
        tick();
        tick();
        run_burst("edge", P - 64'd1, 64'd0, edge_hi, edge_lo, 0);
        tick();
        // start raised in the DONE cycle must not launch a second run
        run_burst("noncanon", P, P + 64'd2, nc_hi, nc_lo, 18);
        tick();
        check("start in DONE ignored busy", {63'd0, bus.busy}, 64'd0);
        tick();
        run_burst("retrig", 64'h0200_0000_0000_0000, 64'h585b_da2e_086e_bc26, pow_hi, pow_lo, 5);
        tick();

        // Reset during the high-half stream
        bus.start = 1'b1;
        bus.w_hi  = 64'h0200_0000_0000_0000;
        bus.w_lo  = 64'h585b_da2e_086e_bc26;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        check("pre-reset c12 rom_w", {62'd0, bus.rom_w}, 64'd1);
        check("pre-reset c12 data", bus.horizontal_data_out, 64'hFFFF_FFFE_FFFC_0001);
        rst_n = 1'b0;
        #1;
        check("midreset rom_w", {62'd0, bus.rom_w}, 64'd0);
        check("midreset data", bus.horizontal_data_out, 64'd0);
        check("midreset busy", {63'd0, bus.busy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midreset done %0d", i), {63'd0, bus.done}, 64'd0);
        end
        rst_n = 1'b1;
        tick();
        run_burst("after reset", P, P + 64'd2, nc_hi, nc_lo, 0);
        tick();

        // Second request issued in the IDLE cycle right after done
        run_burst("b2b first", P - 64'd1, 64'd0, edge_hi, edge_lo, 0);
        run_burst("b2b second", 64'h0200_0000_0000_0000, 64'h585b_da2e_086e_bc26, pow_hi, pow_lo, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
